control_input_conditioner: RTL and testbench

CONTROL_INPUT_CONDITIONER -- requirements
Module: control_input_conditioner

---
 rtl/control_input_conditioner_pkg.sv | 21 ++
 rtl/control_input_conditioner_if.sv | 13 +
 rtl/control_input_conditioner_debounce_channel.sv | 120 ++++++++++++
 rtl/control_input_conditioner.sv | 41 ++++
 tb/tb_control_input_conditioner.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/control_input_conditioner_pkg.sv
// Shared types and timing defaults for the push-button conditioner.
// Holds the repeat FSM state enum and a small width helper.
package control_input_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    REPEATING  = 2'd2
  } rep_state_e;

  // 5 ms / 400 ms / 100 ms at the 74.25 MHz pixel clock
  localparam int unsigned DEF_N_INPUTS        = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 371250;
  localparam int unsigned DEF_REPEAT_DELAY    = 29700000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 7425000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/control_input_conditioner_if.sv
// Button bundle: raw levels in, conditioned level and event pulses out.
interface control_input_conditioner_if #(
  parameter int unsigned N_INPUTS = 2
) ();
  logic [N_INPUTS-1:0] i_raw;
  logic [N_INPUTS-1:0] o_level;
  logic [N_INPUTS-1:0] o_press;
  logic [N_INPUTS-1:0] o_release;
  logic [N_INPUTS-1:0] o_repeat;

  modport master (output i_raw, input o_level, o_press, o_release, o_repeat);
  modport slave  (input i_raw, output o_level, o_press, o_release, o_repeat);
endinterface

// File: rtl/control_input_conditioner_debounce_channel.sv
// One button: 2-flop synchronizer, debounce counter, edge pulses, auto-repeat FSM.
// All outputs are registered; level changes DEBOUNCE_CYCLES+2 cycles after a clean raw change.
module debounce_channel
  import control_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 10,
  parameter int unsigned REPEAT_PERIOD   = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  logic          sync1_q, sync2_q;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          level_q, level_d;
  logic          press_q, release_q, repeat_q, repeat_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  rep_state_e    state_q, state_d;

  logic mismatch, toggle, rise, fall;
  assign mismatch = sync2_q ^ level_q;
  assign toggle   = mismatch && (db_cnt_q == DB_LAST);
  assign rise     = toggle & ~level_q;
  assign fall     = toggle & level_q;

  always_comb begin
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    if (!mismatch) begin
      db_cnt_d = '0;
    end else if (toggle) begin
      db_cnt_d = '0;
      level_d  = ~level_q;
    end else if (db_cnt_q != '1) begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Release wins over a due repeat so no pulse lands on the release edge
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    repeat_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = WAIT_FIRST;
          rcnt_d  = '0;
        end
      end
      WAIT_FIRST: begin
        if (fall) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == RD_LAST) begin
          state_d  = REPEATING;
          rcnt_d   = '0;
          repeat_d = 1'b1;
        end else if (rcnt_q != '1) begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      REPEATING: begin
        if (fall) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == RP_LAST) begin
          rcnt_d   = '0;
          repeat_d = 1'b1;
        end else if (rcnt_q != '1) begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      rcnt_q    <= '0;
      state_q   <= IDLE;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= rise;
      release_q <= fall;
      repeat_q  <= repeat_d;
      rcnt_q    <= rcnt_d;
      state_q   <= state_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;
endmodule

// File: rtl/control_input_conditioner.sv
// Conditions N_INPUTS bouncing push-buttons into debounced levels, press/release and repeat pulses.
// Channels are independent copies of debounce_channel; no backpressure, outputs are free-running.
module control_input_conditioner
  import control_input_conditioner_pkg::*;
#(
  parameter int unsigned N_INPUTS        = DEF_N_INPUTS,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  control_input_conditioner_if.slave   btn
);
  localparam int unsigned DB_CYC = DEBOUNCE_CYCLES;
  localparam int unsigned RP_DLY = REPEAT_DELAY;
  localparam int unsigned RP_PER = REPEAT_PERIOD;

  logic [N_INPUTS-1:0] level, press, rel, rep;

  for (genvar g = 0; g < int'(N_INPUTS); g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DB_CYC),
      .REPEAT_DELAY    (RP_DLY),
      .REPEAT_PERIOD   (RP_PER)
    ) u_ch (
      .clk_i     (i_clk),
      .rst_i     (i_rst),
      .raw_i     (btn.i_raw[g]),
      .level_o   (level[g]),
      .press_o   (press[g]),
      .release_o (rel[g]),
      .repeat_o  (rep[g])
    );
  end

  assign btn.o_level   = level;
  assign btn.o_press   = press;
  assign btn.o_release = rel;
  assign btn.o_repeat  = rep;
endmodule

// File: tb/tb_control_input_conditioner.sv
// Bench: sliding-window reference model feeds a scoreboard queue; a monitor pops one entry per cycle.
module tb_control_input_conditioner;
  localparam int N  = 2;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  control_input_conditioner_if #(.N_INPUTS(N)) bif ();

  control_input_conditioner #(
    .N_INPUTS(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .btn   (bif)
  );

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] rep;
  } obs_t;

  obs_t  exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc   = 0;
  string phase = "reset";

  // Reference: level flips once the last D synchronized samples all disagree with it;
  // repeats fire at ages RD, RD+RP, ... counted from the press edge while held.
  bit [15:0] hist [N];
  bit        m_level [N];
  int        age [N];

  always @(posedge clk) begin : model
    obs_t e;
    bit   all_diff;
    e = '0;
    cyc++;
    for (int c = 0; c < N; c++) begin
      if (rst) begin
        hist[c]    = '0;
        m_level[c] = 1'b0;
        age[c]     = 0;
      end else begin
        all_diff = 1'b1;
        for (int j = 1; j <= D; j++)
          if (hist[c][j] == m_level[c]) all_diff = 1'b0;
        if (all_diff) begin
          if (!m_level[c]) begin
            e.press[c] = 1'b1;
            age[c]     = 0;
          end else begin
            e.rel[c] = 1'b1;
          end
          m_level[c] = ~m_level[c];
        end else if (m_level[c]) begin
          age[c]++;
          if (age[c] >= RD && ((age[c] - RD) % RP) == 0) e.rep[c] = 1'b1;
        end
        hist[c] = {hist[c][14:0], bif.i_raw[c]};
      end
      e.level[c] = m_level[c];
    end
    exp_q.push_back(e);
  end

  initial begin : monitor
    obs_t e, got;
    forever begin
      @(posedge clk);
      #1;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty [%s] cycle %0d: no expected entry", phase, cyc);
      end else begin
        e   = exp_q.pop_front();
        got = {bif.o_level, bif.o_press, bif.o_release, bif.o_repeat};
        if (got !== e) begin
          fails++;
          $display("FAIL scoreboard [%s] cycle %0d: got lvl=%b prs=%b rel=%b rep=%b, expected lvl=%b prs=%b rel=%b rep=%b",
                   phase, cyc, got.level, got.press, got.rel, got.rep, e.level, e.press, e.rel, e.rep);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s [%s] cycle %0d: got %0h expected %0h", nm, phase, cyc, got, exp);
    end
  endtask

  int run [N];
  int rep_cnt;

  initial begin : stimulus
    rst       = 1'b1;
    bif.i_raw = '0;
    @(posedge clk); #1;
    chk("reset_outputs", {bif.o_level, bif.o_press, bif.o_release, bif.o_repeat}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);

    // Clean press and hold: press on edge 5, repeats on 15, 18, 21
    phase = "press_hold";
    bif.i_raw = 2'b01;
    for (int e = 0; e <= 22; e++) begin
      @(posedge clk); #1;
      chk("press_pulse", bif.o_press[0], (e == 5));
      if (e == 4) chk("level_before", bif.o_level[0], 1'b0);
      if (e == 5) chk("level_rise", bif.o_level[0], 1'b1);
      chk("repeat_timing", bif.o_repeat[0], (e == 15 || e == 18 || e == 21));
    end
    @(negedge clk) bif.i_raw = 2'b00;
    for (int e = 0; e <= 12; e++) begin
      @(posedge clk); #1;
      chk("release_pulse", bif.o_release[0], (e == 5));
      if (e >= 5) chk("no_repeat_after_release", bif.o_repeat[0], 1'b0);
    end

    // Bounce shorter than the debounce window
    phase = "bounce";
    @(negedge clk) bif.i_raw = 2'b01;
    repeat (3) @(negedge clk);
    bif.i_raw = 2'b00;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      chk("bounce_quiet", {bif.o_level[0], bif.o_press[0], bif.o_repeat[0]}, 3'b000);
    end

    // Reset in the middle of a hold
    phase = "reset_mid_hold";
    @(negedge clk) bif.i_raw = 2'b01;
    for (int e = 0; e <= 12; e++) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_reset_outputs", {bif.o_level, bif.o_press, bif.o_release, bif.o_repeat}, '0);
    @(negedge clk) rst = 1'b0;
    for (int e = 14; e <= 22; e++) begin
      @(posedge clk); #1;
      chk("post_reset_press", bif.o_press[0], (e == 19));
      chk("post_reset_no_repeat", bif.o_repeat[0], 1'b0);
    end
    @(negedge clk) bif.i_raw = 2'b00;
    repeat (20) @(negedge clk);

    // Simultaneous press, then release of channel 1 only
    phase = "simultaneous";
    bif.i_raw = 2'b11;
    for (int e = 0; e <= 12; e++) begin
      @(posedge clk); #1;
      chk("dual_press", bif.o_press, (e == 5) ? 2'b11 : 2'b00);
    end
    @(negedge clk) bif.i_raw = 2'b01;
    rep_cnt = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      chk("single_release", bif.o_release, (e == 5) ? 2'b10 : 2'b00);
      if (bif.o_repeat[0]) rep_cnt++;
    end
    chk("ch0_keeps_repeating", rep_cnt, 4);
    @(negedge clk) bif.i_raw = 2'b00;
    repeat (20) @(negedge clk);

    // Random bouncing with occasional long holds and resets
    phase = "random";
    for (int c = 0; c < N; c++) run[c] = $urandom_range(1, 12);
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0);
      for (int c = 0; c < N; c++) begin
        run[c]--;
        if (run[c] <= 0) begin
          bif.i_raw[c] = ~bif.i_raw[c];
          run[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 3 * D);
        end
      end
    end
    @(negedge clk);
    rst       = 1'b0;
    bif.i_raw = '0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
